// File: rtl/serial_cmp_pkg.sv
// Shared types and bit-order constants for the bit-serial comparator datapath.
package serial_cmp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BIT_ORDER_MSB = 1;
  localparam int BIT_ORDER_LSB = 0;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register presenting its head bit; shifts toward the head.
// Latency: head valid the cycle after load; no flow control, shifts whenever told.
module serial_shift_reg
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             head
);

  localparam bit HEAD_MSB = (MSB_FIRST == BIT_ORDER_MSB);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= HEAD_MSB ? (q << 1) : (q >> 1);
    end
  end

  assign head = HEAD_MSB ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/serial_operand_serializer.sv
// Serializes an operand pair one bit-pair per cycle and frames it for a serial comparator.
// Latency: first pair one cycle after accept, last after WIDTH; in_ready low while shifting,
// serial side has no back-pressure and one IDLE cycle per word holds the comparator cleared.
module serial_operand_serializer
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = BIT_ORDER_MSB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last,
  output logic             cmp_rst
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1) begin : g_width_check
    $error("serial_operand_serializer: WIDTH must be >= 1");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          first_q, first_nxt;
  logic          load, shift;
  logic          head_a, head_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      first_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      first_q <= first_nxt;
    end
  end

  // Outputs decode state/registers only; in_valid steers next state, never an output.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    first_nxt = first_q;
    load      = 1'b0;
    shift     = 1'b0;
    in_ready  = 1'b0;
    cmp_rst   = 1'b0;
    out_valid = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_a     = 1'b0;
    out_b     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        cmp_rst  = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          cnt_nxt   = CW'(WIDTH - 1);
          first_nxt = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_a     = head_a;
        out_b     = head_b;
        out_first = first_q;
        out_last  = (cnt == '0);
        shift     = 1'b1;
        first_nxt = 1'b0;
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  serial_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_a),
    .head  (head_a)
  );

  serial_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_b),
    .head  (head_b)
  );

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench: 8-bit MSB-first, 8-bit LSB-first and 1-bit serializers with a serial compare model.
module tb_serial_operand_serializer;
  import serial_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: MSB-first, index 1: LSB-first
  logic       iv[2];
  logic [7:0] ia[2];
  logic [7:0] ib[2];
  logic       ir[2], ov[2], oa[2], ob[2], of[2], ol[2], cr[2];

  logic iv1, ia1, ib1, ir1, ov1, oa1, ob1, of1, ol1, cr1;

  serial_operand_serializer #(.WIDTH(8), .MSB_FIRST(BIT_ORDER_MSB)) u_msb (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
    .out_valid(ov[0]), .out_a(oa[0]), .out_b(ob[0]), .out_first(of[0]), .out_last(ol[0]),
    .cmp_rst(cr[0])
  );

  serial_operand_serializer #(.WIDTH(8), .MSB_FIRST(BIT_ORDER_LSB)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]),
    .out_valid(ov[1]), .out_a(oa[1]), .out_b(ob[1]), .out_first(of[1]), .out_last(ol[1]),
    .cmp_rst(cr[1])
  );

  serial_operand_serializer #(.WIDTH(1), .MSB_FIRST(BIT_ORDER_MSB)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(ia1), .in_b(ib1),
    .out_valid(ov1), .out_a(oa1), .out_b(ob1), .out_first(of1), .out_last(ol1),
    .cmp_rst(cr1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_res: 0 = equal, 1 = a greater, 2 = a less
  task automatic send8(input int d, input logic [7:0] a, input logic [7:0] b,
                       input int exp_res, input bit hold, input bit scramble,
                       output int acc);
    int n;
    int res;
    logic [7:0] ga, gb;
    bit msb;
    msb = (d == 0);
    iv[d] = 1'b1;
    ia[d] = a;
    ib[d] = b;
    n = 0;
    while (ir[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 32'(n < 20), 32'd1);
    chk("idle_cmp_rst", cr[d], 1'b1);
    tick();
    acc = cyc;
    if (!hold) iv[d] = 1'b0;
    res = 0;
    ga = '0;
    gb = '0;
    for (int i = 0; i < 8; i++) begin
      if (scramble) begin
        ia[d] = 8'($urandom);
        ib[d] = 8'($urandom);
        iv[d] = 1'($urandom_range(0, 1));
      end
      chk("out_valid", ov[d], 1'b1);
      chk("out_first", of[d], (i == 0));
      chk("out_last", ol[d], (i == 7));
      chk("shift_cmp_rst", cr[d], 1'b0);
      chk("shift_in_ready", ir[d], 1'b0);
      if (msb) begin
        ga = {ga[6:0], oa[d]};
        gb = {gb[6:0], ob[d]};
      end else begin
        ga = {oa[d], ga[7:1]};
        gb = {ob[d], gb[7:1]};
      end
      if (oa[d] !== ob[d]) begin
        if (!msb || res == 0) res = oa[d] ? 1 : 2;
      end
      if (i == 7) chk("cmp_result", res, exp_res);
      tick();
    end
    if (!hold) iv[d] = 1'b0;
    chk("word_a", ga, a);
    chk("word_b", gb, b);
    chk("post_in_ready", ir[d], 1'b1);
    chk("post_out_valid", ov[d], 1'b0);
    chk("post_cmp_rst", cr[d], 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t1, t2, tx;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      ia[d] = '0;
      ib[d] = '0;
    end
    iv1 = 1'b0;
    ia1 = 1'b0;
    ib1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", ir[d], 1'b1);
      chk("rst_cmp_rst", cr[d], 1'b1);
      chk("rst_out_valid", ov[d], 1'b0);
      chk("rst_out_ab", {oa[d], ob[d], of[d], ol[d]}, 4'b0000);
    end
    chk("rst_w1_ready", ir1, 1'b1);
    chk("rst_w1_valid", ov1, 1'b0);

    // MSB-first A5 vs A4 -> a greater
    send8(0, 8'hA5, 8'hA4, 1, 1'b0, 1'b0, tx);
    // LSB-first 01 vs 80 -> a less
    send8(1, 8'h01, 8'h80, 2, 1'b0, 1'b0, tx);

    // back-to-back with in_valid held high
    send8(0, 8'h10, 8'h10, 0, 1'b1, 1'b0, t1);
    send8(0, 8'h0F, 8'hF0, 2, 1'b0, 1'b0, t2);
    chk("accept_gap", t2 - t1, 9);

    // reset after the 3rd bit of a word
    iv[0] = 1'b1;
    ia[0] = 8'h3C;
    ib[0] = 8'hC3;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    chk("mid_valid", ov[0], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", ov[0], 1'b0);
    chk("abort_in_ready", ir[0], 1'b1);
    chk("abort_cmp_rst", cr[0], 1'b1);
    chk("abort_out_last", ol[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_quiet", {ov[0], ol[0]}, 2'b00);
    end

    // operands held against input churn during SHIFT
    send8(0, 8'h5A, 8'h5B, 2, 1'b0, 1'b1, tx);
    send8(1, 8'hC3, 8'h3C, 1, 1'b0, 1'b1, tx);

    // WIDTH=1 single-cycle word
    iv1 = 1'b1;
    ia1 = 1'b1;
    ib1 = 1'b0;
    tick();
    iv1 = 1'b0;
    chk("w1_valid", ov1, 1'b1);
    chk("w1_first_last", {of1, ol1}, 2'b11);
    chk("w1_pair", {oa1, ob1}, 2'b10);
    chk("w1_cmp_rst", cr1, 1'b0);
    chk("w1_busy", ir1, 1'b0);
    tick();
    chk("w1_ready_back", ir1, 1'b1);
    chk("w1_idle", ov1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
